// File: rtl/mnem_decode.sv
// mnem_decode: serial ASCII mnemonic decoder for the simplecore debug/trace
// console. Collects one whitespace-delimited token a character at a time,
// folds it to uppercase and maps it to an instruction class code or an
// ALU control code. Unknown, over-long or illegal-character tokens are
// reported as errors and counted in a saturating counter.
//
// Instruction class codes: ALUI=0 ALUR=1 SHRO=2 LOAD=3 STORE=4 BRANCH=5
// MUL=6; 3'b111 marks "no instruction" (error or ALU token).
`timescale 1ns/1ps

`ifndef INST_ALUI
`define INST_ALUI   3'd0
`define INST_ALUR   3'd1
`define INST_SHRO   3'd2
`define INST_LOAD   3'd3
`define INST_STORE  3'd4
`define INST_BRANCH 3'd5
`define INST_MUL    3'd6
`endif

module mnem_decode #(
    parameter int MAXLEN    = 6,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ch_valid,
    input  logic [7:0]           ch_data,
    output logic                 ch_ready,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic                 tok_is_alu,
    output logic [2:0]           tok_inst_id,
    output logic [2:0]           tok_alu_ctl,
    output logic                 tok_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                BUF_W = 8 * MAXLEN;
    localparam int                LEN_W = $clog2(MAXLEN + 1);
    localparam logic [BUF_W-1:0]  BLANK = {MAXLEN{8'h20}};

    typedef enum logic [1:0] {IDLE, ACCUM, SKIP, OUT} state_t;

    state_t                 state_q;
    logic [BUF_W-1:0]       buf_q;
    logic [LEN_W-1:0]       len_q;
    logic                   bad_q;
    logic                   tok_valid_q;
    logic                   tok_is_alu_q;
    logic [2:0]             tok_inst_id_q;
    logic [2:0]             tok_alu_ctl_q;
    logic                   tok_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   take;
    logic                   is_delim;
    logic                   is_legal;
    logic [7:0]             ch_up;
    logic [BUF_W-1:0]       buf_wr;
    logic                   dec_hit;
    logic                   dec_alu;
    logic [2:0]             dec_code;
    logic                   err_tok;

    // Exact match of the space-padded buffer against a 6-character literal.
    // Literal characters that do not fit in the buffer must be spaces.
    function automatic logic mnem_match(input logic [BUF_W-1:0] b,
                                        input logic [47:0]      lit);
        logic       ok;
        logic [7:0] want;
        ok = 1'b1;
        for (int i = 0; i < MAXLEN; i++) begin
            want = (i < 6) ? lit[47-8*(i%6) -: 8] : 8'h20;
            if (b[BUF_W-1-8*i -: 8] != want) ok = 1'b0;
        end
        for (int i = MAXLEN; i < 6; i++) begin
            if (lit[47-8*i -: 8] != 8'h20) ok = 1'b0;
        end
        return ok;
    endfunction

    assign ch_ready    = (state_q != OUT);
    assign take        = ch_valid && ch_ready;
    assign tok_valid   = tok_valid_q;
    assign tok_is_alu  = tok_is_alu_q;
    assign tok_inst_id = tok_inst_id_q;
    assign tok_alu_ctl = tok_alu_ctl_q;
    assign tok_err     = tok_err_q;
    assign err_cnt     = err_cnt_q;

    // Classify the incoming character and fold lowercase to uppercase.
    always_comb begin
        is_delim = (ch_data == 8'h20) || (ch_data == 8'h09) ||
                   (ch_data == 8'h0A) || (ch_data == 8'h0D);
        is_legal = (ch_data >= 8'h21) && (ch_data <= 8'h7E);
        ch_up    = ((ch_data >= 8'h61) && (ch_data <= 8'h7A)) ? ch_data - 8'h20 : ch_data;
    end

    // Buffer image with the incoming character written at position len_q.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        buf_wr = buf_q;
        for (int i = 0; i < MAXLEN; i++) begin
            if (LEN_W'(i) == len_q) buf_wr[BUF_W-1-8*i -: 8] = ch_up;
        end
    end

    // Table lookup of the collected token (delimiter itself is never stored).
    always_comb begin
        dec_hit  = 1'b1;
        dec_alu  = 1'b0;
        dec_code = 3'b111;
        if      (mnem_match(buf_q, "ALUI  ")) dec_code = `INST_ALUI;
        else if (mnem_match(buf_q, "ALUR  ")) dec_code = `INST_ALUR;
        else if (mnem_match(buf_q, "SHRO  ")) dec_code = `INST_SHRO;
        else if (mnem_match(buf_q, "LOAD  ")) dec_code = `INST_LOAD;
        else if (mnem_match(buf_q, "STORE ")) dec_code = `INST_STORE;
        else if (mnem_match(buf_q, "BRANCH")) dec_code = `INST_BRANCH;
        else if (mnem_match(buf_q, "MUL   ")) dec_code = `INST_MUL;
        else if (mnem_match(buf_q, "MOVA  ")) begin dec_alu = 1'b1; dec_code = 3'b000; end
        else if (mnem_match(buf_q, "MOVB  ")) begin dec_alu = 1'b1; dec_code = 3'b001; end
        else if (mnem_match(buf_q, "AND   ")) begin dec_alu = 1'b1; dec_code = 3'b010; end
        else if (mnem_match(buf_q, "OR    ")) begin dec_alu = 1'b1; dec_code = 3'b011; end
        else if (mnem_match(buf_q, "ADD   ")) begin dec_alu = 1'b1; dec_code = 3'b100; end
        else if (mnem_match(buf_q, "SUB   ")) begin dec_alu = 1'b1; dec_code = 3'b110; end
        else dec_hit = 1'b0;
        err_tok = bad_q || !dec_hit;
    end

    // Token FSM with registered outputs and the saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            buf_q         <= BLANK;
            len_q         <= '0;
            bad_q         <= 1'b0;
            tok_valid_q   <= 1'b0;
            tok_is_alu_q  <= 1'b0;
            tok_inst_id_q <= 3'b111;
            tok_alu_ctl_q <= 3'b000;
            tok_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state_q)
                IDLE: begin
                    if (take && !is_delim) begin
                        buf_q   <= buf_wr;
                        len_q   <= LEN_W'(1);
                        bad_q   <= !is_legal;
                        state_q <= ACCUM;
                    end
                end
                ACCUM, SKIP: begin
                    if (take) begin
                        if (is_delim) begin
                            tok_valid_q   <= 1'b1;
                            tok_err_q     <= err_tok;
                            tok_is_alu_q  <= !err_tok && dec_alu;
                            tok_inst_id_q <= (err_tok || dec_alu) ? 3'b111 : dec_code;
                            tok_alu_ctl_q <= (!err_tok && dec_alu) ? dec_code : 3'b000;
                            if (err_tok && (err_cnt_q != '1))
                                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                            state_q       <= OUT;
                        end else if (state_q == ACCUM) begin
                            if (int'(len_q) < MAXLEN) begin
                                buf_q <= buf_wr;
                                len_q <= len_q + LEN_W'(1);
                                bad_q <= bad_q || !is_legal;
                            end else begin
                                bad_q   <= 1'b1;
                                state_q <= SKIP;
                            end
                        end
                    end
                end
                OUT: begin
                    if (tok_ready) begin
                        tok_valid_q <= 1'b0;
                        buf_q       <= BLANK;
                        len_q       <= '0;
                        bad_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mnem_decode.sv
// tb_mnem_decode: directed stimulus for mnem_decode with a string-level
// reference model (token text -> code tables) and a per-cycle compare
// process that checks every token handshake and output stability while
// the consumer stalls.
`timescale 1ns/1ps

module tb_mnem_decode;

    localparam int MAXLEN = 6;

    localparam logic [2:0] I_ALUI = 3'd0, I_ALUR = 3'd1, I_SHRO = 3'd2, I_LOAD = 3'd3,
                           I_STORE = 3'd4, I_BRANCH = 3'd5, I_MUL = 3'd6;

    typedef struct {
        bit         is_alu;
        logic [2:0] inst;
        logic [2:0] alu;
        bit         err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ch_valid = 1'b0;
    logic [7:0] ch_data = 8'h20;
    logic       ch_ready;
    logic       tok_valid;
    logic       tok_ready = 1'b1;
    logic       tok_is_alu;
    logic [2:0] tok_inst_id;
    logic [2:0] tok_alu_ctl;
    logic       tok_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [2:0] inst_tab[string];
    logic [2:0] alu_tab[string];
    exp_t       exp_q[$];
    string      cur_str = "";
    int         cur_len = 0;
    bit         cur_bad = 1'b0;
    int         model_cnt = 0;
    bit         stall_mode = 1'b0;
    int         stall_cnt = 0;

    mnem_decode #(.MAXLEN(MAXLEN), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_is_alu (tok_is_alu),
        .tok_inst_id(tok_inst_id),
        .tok_alu_ctl(tok_alu_ctl),
        .tok_err    (tok_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: a token is an error if flagged bad or absent from both tables.
    function automatic exp_t model_decode(input string s, input bit bad);
        exp_t e;
        e.is_alu = 1'b0; e.inst = 3'b111; e.alu = 3'b000; e.err = 1'b1; e.cnt = 8'h00;
        if (!bad && inst_tab.exists(s)) begin
            e.inst = inst_tab[s]; e.err = 1'b0;
        end else if (!bad && alu_tab.exists(s)) begin
            e.is_alu = 1'b1; e.alu = alu_tab[s]; e.err = 1'b0;
        end
        return e;
    endfunction

    // Reference tokenizer fed with every accepted character.
    task automatic model_feed(input logic [7:0] c);
        exp_t e;
        logic [7:0] u;
        if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) begin
            if (cur_len > 0) begin
                e = model_decode(cur_str, cur_bad);
                if (e.err && model_cnt < 255) model_cnt++;
                e.cnt = 8'(model_cnt);
                exp_q.push_back(e);
            end
            cur_str = ""; cur_len = 0; cur_bad = 1'b0;
        end else if (cur_len < MAXLEN) begin
            u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
            cur_str = $sformatf("%s%c", cur_str, u);
            cur_len++;
            if (c < 8'h21 || c > 8'h7E) cur_bad = 1'b1;
        end else begin
            cur_bad = 1'b1;
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        bit acc;
        bit done;
        done = 1'b0;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = c;
        for (int n = 0; n < 200 && !done; n++) begin
            acc = ch_ready;
            @(posedge clk);
            if (acc) done = 1'b1;
            else @(negedge clk);
        end
        if (done) model_feed(c);
        else check("char_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tok_valid) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
    endtask

    // Consumer that holds tok_ready low for 5 cycles on each token when stalling.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_mode) begin
            if (tok_valid) begin
                if (stall_cnt >= 5) tok_ready = 1'b1;
                else begin tok_ready = 1'b0; stall_cnt++; end
            end else begin
                tok_ready = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Compare process: token content at each handshake, stability under stall.
    initial begin
        logic [10:0] prev_out;
        bit          prev_valid;
        bit          prev_ready;
        int          wait_cyc;
        exp_t        e;
        prev_out = '0; prev_valid = 1'b0; prev_ready = 1'b1; wait_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                wait_cyc = 0;
            end else begin
                if (tok_valid && prev_valid && !prev_ready)
                    check("stall_hold", {21'd0, tok_is_alu, tok_inst_id, tok_alu_ctl, tok_err, err_cnt[2:0]},
                          {21'd0, prev_out});
                if (tok_valid && tok_ready) begin
                    wait_cyc = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_token", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tok_err", 32'(tok_err), 32'(e.err));
                        check("tok_is_alu", 32'(tok_is_alu), 32'(e.is_alu));
                        if (e.err || !e.is_alu) check("tok_inst_id", 32'(tok_inst_id), 32'(e.inst));
                        if (e.err || e.is_alu)  check("tok_alu_ctl", 32'(tok_alu_ctl), 32'(e.alu));
                        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
                    end
                end else if (exp_q.size() != 0) begin
                    wait_cyc++;
                    if (wait_cyc > 100) begin
                        check("token_timeout", 32'd0, 32'd1);
                        exp_q.delete();
                        wait_cyc = 0;
                    end
                end
                prev_out   = {tok_is_alu, tok_inst_id, tok_alu_ctl, tok_err, err_cnt[2:0]};
                prev_valid = tok_valid;
                prev_ready = tok_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        inst_tab["ALUI"] = I_ALUI;   inst_tab["ALUR"] = I_ALUR;   inst_tab["SHRO"] = I_SHRO;
        inst_tab["LOAD"] = I_LOAD;   inst_tab["STORE"] = I_STORE; inst_tab["BRANCH"] = I_BRANCH;
        inst_tab["MUL"] = I_MUL;
        alu_tab["MOVA"] = 3'b000; alu_tab["MOVB"] = 3'b001; alu_tab["AND"] = 3'b010;
        alu_tab["OR"] = 3'b011;   alu_tab["ADD"] = 3'b100;  alu_tab["SUB"] = 3'b110;

        // Pin the model against hand-computed values.
        m = model_decode("LOAD", 1'b0);   check("model_load", {m.is_alu, m.err, m.inst}, {1'b0, 1'b0, 3'd3});
        m = model_decode("SUB", 1'b0);    check("model_sub", {m.is_alu, m.err, m.alu}, {1'b1, 1'b0, 3'b110});
        m = model_decode("LOA", 1'b0);    check("model_loa", {m.err, m.inst}, {1'b1, 3'b111});
        m = model_decode("BRANCH", 1'b1); check("model_bad", {m.err, m.inst}, {1'b1, 3'b111});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_tok_valid", 32'(tok_valid), 32'd0);
        check("rst_is_alu", 32'(tok_is_alu), 32'd0);
        check("rst_inst_id", 32'(tok_inst_id), 32'h7);
        check("rst_alu_ctl", 32'(tok_alu_ctl), 32'd0);
        check("rst_tok_err", 32'(tok_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_ch_ready", 32'(ch_ready), 32'd1);
        rst_n = 1'b1;

        // "load\n": latency and single-cycle ch_ready drop.
        send_char("l"); send_char("o"); send_char("a"); send_char("d"); send_char(8'h0A);
        @(negedge clk);
        ch_valid = 1'b0;
        check("load_valid", 32'(tok_valid), 32'd1);
        check("load_ch_ready", 32'(ch_ready), 32'd0);
        check("load_inst", {tok_is_alu, tok_err, tok_inst_id}, {1'b0, 1'b0, I_LOAD});
        @(negedge clk);
        check("load_ch_ready_back", 32'(ch_ready), 32'd1);
        check("load_valid_drop", 32'(tok_valid), 32'd0);
        wait_drain();

        send_str("  SUB ");
        wait_drain();

        // Back-to-back tokens with a stalling consumer.
        stall_mode = 1'b1;
        tok_ready  = 1'b0;
        send_str("ADD OR MOVB ");
        wait_drain();
        stall_mode = 1'b0;
        @(negedge clk);
        tok_ready = 1'b1;

        send_str("BRANCHX LOA\n");
        wait_drain();
        check("err_cnt_two", 32'(err_cnt), 32'd2);
        send_str("BRANCH ");
        wait_drain();

        send_str({"MU", 8'h01, "L "});
        wait_drain();
        for (int i = 0; i < 256; i++) send_str("X ");
        wait_drain();
        check("err_cnt_sat", 32'(err_cnt), 32'hFF);

        // Reset in the middle of a token.
        send_str("STO");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tok_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        cur_str = ""; cur_len = 0; cur_bad = 1'b0; model_cnt = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_str("STORE\r");
        wait_drain();
        send_str("alui shro mul mova and alur ");
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
